// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT butterfly schedule: load, per-stage issue with drain, done pulse; done at 2+LOG2_N*(N/2+BFLY_LATENCY).
// stall holds issue only in RUN; optional macro FFT_SEQ_INVERSE_EN adds inverse/tw_conj.
module fft_stage_sequencer #(
  parameter int N_POINTS     = 64,
  parameter int LOG2_N       = 6,
  parameter int BFLY_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stall,
  output logic                        busy,
  output logic                        load_en,
  output logic                        issue_valid,
  output logic [LOG2_N-1:0]           idx_a,
  output logic [LOG2_N-1:0]           idx_b,
  output logic [LOG2_N-2:0]           tw_idx,
  output logic [$clog2(LOG2_N)-1:0]   stage,
  output logic                        wb_valid,
  output logic [LOG2_N-1:0]           wb_idx_a,
  output logic [LOG2_N-1:0]           wb_idx_b,
  output logic                        done
`ifdef FFT_SEQ_INVERSE_EN
  , input  logic                      inverse
  , output logic                      tw_conj
`endif
);

  localparam int SW = $clog2(LOG2_N);
  localparam logic [LOG2_N-2:0] BC_LAST    = (LOG2_N-1)'(N_POINTS/2 - 1);
  localparam logic [LOG2_N-2:0] BC_ONE     = (LOG2_N-1)'(1);
  localparam logic [SW-1:0]     STAGE_LAST = SW'(LOG2_N - 1);
  localparam logic [SW-1:0]     STAGE_ONE  = SW'(1);
  localparam logic [1:0]        DC_LAST    = 2'(BFLY_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [LOG2_N-2:0] bc;
  logic [1:0]        dc;

  logic [LOG2_N-2:0] low_mask;
  logic [LOG2_N-2:0] low_b;
  logic [LOG2_N-1:0] half_w;
  logic [LOG2_N-1:0] a_w;
  logic [LOG2_N-2:0] tw_w;
  logic [SW:0]       stage_p1;
  logic [SW:0]       tw_sh;

  // Index arithmetic for the butterfly at (stage, bc); mask built by right shift so it never overflows.
  always_comb begin
    stage_p1 = {1'b0, stage} + (SW+1)'(1);
    tw_sh    = (SW+1)'(LOG2_N - 1) - {1'b0, stage};
    low_mask = {(LOG2_N-1){1'b1}} >> tw_sh;
    low_b    = bc & low_mask;
    half_w   = LOG2_N'(1) << stage;
    a_w      = (({1'b0, bc} >> stage) << stage_p1) | {1'b0, low_b};
    tw_w     = low_b << tw_sh;
  end

`ifdef FFT_SEQ_INVERSE_EN
  logic inv_r;
  assign tw_conj = busy & inv_r;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bc          <= '0;
      dc          <= '0;
      stage       <= '0;
      busy        <= 1'b0;
      load_en     <= 1'b0;
      issue_valid <= 1'b0;
      idx_a       <= '0;
      idx_b       <= '0;
      tw_idx      <= '0;
      done        <= 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
      inv_r       <= 1'b0;
`endif
    end else begin
      load_en     <= 1'b0;
      issue_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
`ifdef FFT_SEQ_INVERSE_EN
            inv_r <= inverse;
`endif
          end
        end
        LOAD: begin
          load_en <= 1'b1;
          stage   <= '0;
          bc      <= '0;
          state   <= RUN;
        end
        RUN: begin
          if (!stall) begin
            issue_valid <= 1'b1;
            idx_a       <= a_w;
            idx_b       <= a_w | half_w;
            tw_idx      <= tw_w;
            if (bc == BC_LAST) begin
              state <= DRAIN;
              dc    <= '0;
            end else begin
              bc <= bc + BC_ONE;
            end
          end
        end
        DRAIN: begin
          // Wait out the datapath so the next stage never reads a pending writeback.
          if (dc == DC_LAST) begin
            if (stage == STAGE_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              stage <= stage + STAGE_ONE;
              bc    <= '0;
              state <= RUN;
            end
          end else begin
            dc <= dc + 2'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic              wb_v_p [BFLY_LATENCY];
  logic [LOG2_N-1:0] wb_a_p [BFLY_LATENCY];
  logic [LOG2_N-1:0] wb_b_p [BFLY_LATENCY];

  // Writeback delay line shifts every cycle, so stall bubbles propagate as invalid slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BFLY_LATENCY; i++) begin
        wb_v_p[i] <= 1'b0;
        wb_a_p[i] <= '0;
        wb_b_p[i] <= '0;
      end
    end else begin
      wb_v_p[0] <= issue_valid;
      wb_a_p[0] <= idx_a;
      wb_b_p[0] <= idx_b;
      for (int i = 1; i < BFLY_LATENCY; i++) begin
        wb_v_p[i] <= wb_v_p[i-1];
        wb_a_p[i] <= wb_a_p[i-1];
        wb_b_p[i] <= wb_b_p[i-1];
      end
    end
  end

  assign wb_valid = wb_v_p[BFLY_LATENCY-1];
  assign wb_idx_a = wb_a_p[BFLY_LATENCY-1];
  assign wb_idx_b = wb_b_p[BFLY_LATENCY-1];

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control sequencer for the in-place radix-2 DIT butterfly datapath that operates on the 64-entry Re/Im register bank.
- On a start handshake it does three things: issues one load of the input vector, walks every stage/butterfly pair with its twiddle index, and enforces a pipeline drain between stages so there are no read-after-write hazards.
- It signals completion with a one-cycle done pulse.
- It replaces the free-running count/stage logic with a single FSM-owned schedule.

Parameters:
- N_POINTS, 64, transform size; power of two, 4..1024.
- LOG2_N, 6, log2(N_POINTS).
- BFLY_LATENCY, 1, cycles from issue to register-bank writeback; legal range 1..4.

Ports:
- clk  input  1  clock; all flops update on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request a transform; sampled in IDLE only.
- stall  input  1  hold issue while high; honoured only in RUN.
- busy  output  1  high in LOAD, RUN and DRAIN.
- load_en  output  1  one-cycle strobe: datapath captures the input vector into the register bank.
- issue_valid  output  1  butterfly issued this cycle.
- idx_a  output  LOG2_N  bank index of the upper operand.
- idx_b  output  LOG2_N  bank index of the lower operand (idx_a + 2^stage).
- tw_idx  output  LOG2_N-1  twiddle ROM index.
- stage  output  $clog2(LOG2_N)  current stage, 0..LOG2_N-1.
- wb_valid  output  1  writeback strobe; issue_valid delayed BFLY_LATENCY cycles.
- wb_idx_a  output  LOG2_N  idx_a delayed BFLY_LATENCY cycles.
- wb_idx_b  output  LOG2_N  idx_b delayed BFLY_LATENCY cycles.
- done  output  1  one-cycle pulse when the final writeback has completed.

Behaviour:
- Reset (rst low, any time, including mid-transform):
  - state goes to IDLE.
  - All outputs go to 0, and the wb delay line is cleared.
  - No partial writeback is emitted after reset release.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - Moves to LOAD when start=1.
  - start in any other state is ignored; there is no queuing.
- LOAD:
  - Lasts exactly one cycle, with load_en=1.
  - Clears stage=0 and the butterfly counter bc=0, then moves to RUN.
- RUN:
  - When stall=0: issue_valid=1 and the indices below are driven; bc increments.
  - When stall=1: issue_valid=0, and bc and stage hold.
  - After bc=N/2-1 issues, moves to DRAIN.
- Index arithmetic, with half=2^stage:
  - idx_a = ((bc>>stage)<<(stage+1)) | (bc & (half-1)).
  - idx_b = idx_a | half.
  - tw_idx = (bc & (half-1)) << (LOG2_N-1-stage).
  - All values are unsigned and truncated to port width; there is no overflow by construction.
- DRAIN:
  - Lasts exactly BFLY_LATENCY cycles with issue_valid=0; stall is ignored.
  - Exit when stage<LOG2_N-1: stage increments, bc clears to 0, state returns to RUN.
  - Exit on the last stage: state moves to DONE.
- DONE:
  - Lasts one cycle with done=1, busy=0, then returns to IDLE.
  - start in the DONE cycle is ignored.
- Writeback path:
  - wb_* is a BFLY_LATENCY-deep shift register of {issue_valid, idx_a, idx_b}.
  - It shifts every cycle, including stall cycles (a bubble is inserted).
  - The last writeback of each stage lands in the final DRAIN cycle.
- Outputs idx_*, tw_idx and stage are registered; they hold their last value when issue_valid=0.
- Latency with no stalls (start sampled at cycle 0):
  - load_en at cycle 1.
  - First issue at cycle 2.
  - done at cycle 2 + LOG2_N*(N/2 + BFLY_LATENCY); this is 200 for the default parameters.
  - Each stall cycle in RUN adds 1 cycle.

Optional Feature:
- Macro: FFT_SEQ_INVERSE_EN.
- When defined:
  - Adds input inverse (1 bit), sampled with start in IDLE.
  - Adds output tw_conj (1 bit), equal to the latched inverse while busy and 0 otherwise.
  - The datapath uses tw_conj to conjugate twiddles for the IFFT.
  - The latch is cleared by reset and re-sampled only on an accepted start.
- When not defined: neither port exists, and behaviour is forward-FFT only.

Test Plan:
- Defaults, pulse start at cycle 0 with no stall:
  - load_en=1 at cycle 1.
  - Stage 0 first issue (a,b,tw)=(0,1,0), next (2,3,0).
  - Stage 5 last issue (31,63,31).
  - done=1 at cycle 200 only.
  - Exactly 192 issue_valid and 192 wb_valid pulses.
- Index spot checks:
  - Stage 1, bc=1 -> (1,3,16).
  - Stage 2, bc=5 -> (9,13,8).
  - Every stage covers all 64 indices exactly once across idx_a ∪ idx_b.
- Hold stall=1 for cycles 10..14 in stage 0:
  - No issue during those cycles.
  - Issue sequence resumes at bc=8 unbroken.
  - done moves to cycle 205.
- BFLY_LATENCY=3:
  - 3 idle cycles between stages.
  - wb_idx for each pair appears 3 cycles after its issue.
  - done at 2 + 6*35 = 212.
- Pulse rst low at cycle 50 mid-RUN:
  - All outputs are 0 immediately.
  - No wb_valid after release.
  - A new start yields the full 200-cycle sequence from (0,1,0).
- start held high through the whole run:
  - Ignored while busy and in the DONE cycle.
  - A second transform begins from IDLE, with load_en 2 cycles after done.
